// File: rtl/sphere_hit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sphere_hit_scheduler
// Description : Initiator side of the sphere hit-test interface. Accepts one
//               ray plus a contiguous sphere index range, streams spheres from
//               primitive memory into an external combinational SphereHit
//               instance one per cycle, and reduces the returned HitData to the
//               nearest hit (or the first hit in any-hit mode).
//
//               Flattened bus layouts (MSB first):
//                 HitData : {bHit, T[FIX_W], pi[PI_W], color[COL_W], st[ST_W]}
//                 Fixed   : signed two's complement
//               PI_W must be at least IDX_W; pi is the zero-extended address.
// Revision    : 1.0 - initial release
// ============================================================================
module sphere_hit_scheduler #(
    parameter int IDX_W = 6,
    parameter int FIX_W = 32,
    parameter int RAY_W = 6 * FIX_W,
    parameter int SPH_W = 4 * FIX_W,
    parameter int COL_W = 24,
    parameter int ST_W  = 2,
    parameter int PI_W  = 16,
    parameter int HIT_W = 1 + FIX_W + PI_W + COL_W + ST_W
) (
    input  logic               clk,
    input  logic               reset,
    // request
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [RAY_W-1:0]   i_ray,
    input  logic [IDX_W-1:0]   i_first,
    input  logic [IDX_W:0]     i_count,
    input  logic               i_any_hit,
    // primitive memory
    output logic               o_sph_rd,
    output logic [IDX_W-1:0]   o_sph_addr,
    input  logic [SPH_W-1:0]   i_sph_data,
    input  logic [COL_W-1:0]   i_sph_color,
    input  logic [ST_W-1:0]    i_sph_st,
    // SphereHit tester
    output logic [RAY_W-1:0]   o_test_ray,
    output logic [SPH_W-1:0]   o_test_sphere,
    output logic [COL_W-1:0]   o_test_color,
    output logic [PI_W-1:0]    o_test_pi,
    output logic [ST_W-1:0]    o_test_st,
    input  logic [HIT_W-1:0]   i_test_hit,
    // result
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [HIT_W-1:0]   o_res_hit
);

    localparam int HIT_BIT = HIT_W - 1;
    localparam int T_MSB   = HIT_W - 2;
    localparam int T_LSB   = HIT_W - 1 - FIX_W;

    localparam logic [IDX_W:0]   C_CNT_ONE  = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   C_CNT_ZERO = '0;
    localparam logic [IDX_W-1:0] C_ADR_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q,       state_d;
    logic [RAY_W-1:0]     ray_q,         ray_d;
    logic [IDX_W-1:0]     addr_q,        addr_d;
    logic [IDX_W:0]       rem_q,         rem_d;
    logic                 any_hit_q,     any_hit_d;
    logic [HIT_W-1:0]     best_q,        best_d;
    logic                 rd_q,          rd_d;
    logic [IDX_W-1:0]     rd_addr_q,     rd_addr_d;
    logic                 test_vld_q,    test_vld_d;
    logic [RAY_W-1:0]     test_ray_q,    test_ray_d;
    logic [SPH_W-1:0]     test_sphere_q, test_sphere_d;
    logic [COL_W-1:0]     test_color_q,  test_color_d;
    logic [PI_W-1:0]      test_pi_q,     test_pi_d;
    logic [ST_W-1:0]      test_st_q,     test_st_d;

    logic                 w_sph_rd;
    logic                 w_abort;
    logic                 w_closer;
    logic [FIX_W-1:0]     w_hit_t;
    logic [FIX_W-1:0]     w_best_t;

    assign w_hit_t  = i_test_hit[T_MSB:T_LSB];
    assign w_best_t = best_q[T_MSB:T_LSB];

    // Candidate beats the current best: strict signed compare so ties keep the earlier sphere
    assign w_closer = i_test_hit[HIT_BIT] &&
                      (!best_q[HIT_BIT] || ($signed(w_hit_t) < $signed(w_best_t)));

    // Any-hit termination: first valid hit ends the scan and discards everything in flight
    assign w_abort  = test_vld_q && any_hit_q && i_test_hit[HIT_BIT];

    // Next-state, read issue, pipeline load and reduction
    always_comb begin
        state_d       = state_q;
        ray_d         = ray_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        any_hit_d     = any_hit_q;
        best_d        = best_q;
        rd_d          = 1'b0;
        rd_addr_d     = rd_addr_q;
        test_vld_d    = 1'b0;
        test_ray_d    = test_ray_q;
        test_sphere_d = test_sphere_q;
        test_color_d  = test_color_q;
        test_pi_d     = test_pi_q;
        test_st_d     = test_st_q;
        w_sph_rd      = 1'b0;

        // Stage 2: fold the tester result into the running best
        if (test_vld_q && w_closer) begin
            best_d = i_test_hit;
        end

        // Stage 1: register the memory data returned for last cycle's read
        if (rd_q && !w_abort) begin
            test_vld_d    = 1'b1;
            test_ray_d    = ray_q;
            test_sphere_d = i_sph_data;
            test_color_d  = i_sph_color;
            test_pi_d     = PI_W'(rd_addr_q);
            test_st_d     = i_sph_st;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    ray_d     = i_ray;
                    addr_d    = i_first;
                    rem_d     = i_count;
                    any_hit_d = i_any_hit;
                    best_d    = '0;
                    state_d   = (i_count == C_CNT_ZERO) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!w_abort) begin
                    w_sph_rd  = 1'b1;
                    rd_d      = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + C_ADR_ONE;
                    rem_d     = rem_q - C_CNT_ONE;
                    if (rem_q == C_CNT_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // With no read outstanding, stage 2 is being reduced now and the pipe is empty next cycle
                if (!rd_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_abort) begin
            rd_d       = 1'b0;
            test_vld_d = 1'b0;
            state_d    = ST_DONE;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ray_q         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            any_hit_q     <= 1'b0;
            best_q        <= '0;
            rd_q          <= 1'b0;
            rd_addr_q     <= '0;
            test_vld_q    <= 1'b0;
            test_ray_q    <= '0;
            test_sphere_q <= '0;
            test_color_q  <= '0;
            test_pi_q     <= '0;
            test_st_q     <= '0;
        end else begin
            state_q       <= state_d;
            ray_q         <= ray_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            any_hit_q     <= any_hit_d;
            best_q        <= best_d;
            rd_q          <= rd_d;
            rd_addr_q     <= rd_addr_d;
            test_vld_q    <= test_vld_d;
            test_ray_q    <= test_ray_d;
            test_sphere_q <= test_sphere_d;
            test_color_q  <= test_color_d;
            test_pi_q     <= test_pi_d;
            test_st_q     <= test_st_d;
        end
    end

    assign o_req_ready   = (state_q == ST_IDLE);
    assign o_sph_rd      = w_sph_rd;
    assign o_sph_addr    = addr_q;
    assign o_res_valid   = (state_q == ST_DONE);
    assign o_res_hit     = best_q;
    assign o_test_ray    = test_ray_q;
    assign o_test_sphere = test_sphere_q;
    assign o_test_color  = test_color_q;
    assign o_test_pi     = test_pi_q;
    assign o_test_st     = test_st_q;

endmodule
`default_nettype wire

// File: tb/tb_sphere_hit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sphere_hit_scheduler
// Description : Bench for sphere_hit_scheduler. Provides a primitive memory,
//               a SphereHit stand-in (hit flag and T come from the sphere word,
//               T is offset by the ray's low word) and a reference model that
//               predicts read addresses, result latency and the reduced hit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sphere_hit_scheduler;

    localparam int IDX_W = 6;
    localparam int FIX_W = 32;
    localparam int RAY_W = 192;
    localparam int SPH_W = 128;
    localparam int COL_W = 24;
    localparam int ST_W  = 2;
    localparam int PI_W  = 16;
    localparam int HIT_W = 75;
    localparam int N     = 64;

    localparam logic [31:0] FX_0_25 = 32'h0000_4000;
    localparam logic [31:0] FX_0_5  = 32'h0000_8000;
    localparam logic [31:0] FX_1    = 32'h0001_0000;
    localparam logic [31:0] FX_2    = 32'h0002_0000;
    localparam logic [31:0] FX_3    = 32'h0003_0000;
    localparam logic [31:0] FX_4    = 32'h0004_0000;
    localparam logic [31:0] FX_5    = 32'h0005_0000;
    localparam logic [31:0] FX_7    = 32'h0007_0000;
    localparam logic [31:0] FX_10   = 32'h000A_0000;
    localparam logic [31:0] FX_M1_5 = 32'hFFFE_8000;
    localparam logic [31:0] FX_M0_5 = 32'hFFFF_8000;
    localparam logic [31:0] FX_MIN  = 32'h8000_0000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               i_req_valid = 1'b0;
    logic               o_req_ready;
    logic [RAY_W-1:0]   i_ray = '0;
    logic [IDX_W-1:0]   i_first = '0;
    logic [IDX_W:0]     i_count = '0;
    logic               i_any_hit = 1'b0;
    logic               o_sph_rd;
    logic [IDX_W-1:0]   o_sph_addr;
    logic [SPH_W-1:0]   i_sph_data = '0;
    logic [COL_W-1:0]   i_sph_color = '0;
    logic [ST_W-1:0]    i_sph_st = '0;
    logic [RAY_W-1:0]   o_test_ray;
    logic [SPH_W-1:0]   o_test_sphere;
    logic [COL_W-1:0]   o_test_color;
    logic [PI_W-1:0]    o_test_pi;
    logic [ST_W-1:0]    o_test_st;
    logic [HIT_W-1:0]   i_test_hit;
    logic               o_res_valid;
    logic               i_res_ready = 1'b0;
    logic [HIT_W-1:0]   o_res_hit;

    always #5 clk = ~clk;

    sphere_hit_scheduler #(.IDX_W(IDX_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_ray         (i_ray),
        .i_first       (i_first),
        .i_count       (i_count),
        .i_any_hit     (i_any_hit),
        .o_sph_rd      (o_sph_rd),
        .o_sph_addr    (o_sph_addr),
        .i_sph_data    (i_sph_data),
        .i_sph_color   (i_sph_color),
        .i_sph_st      (i_sph_st),
        .o_test_ray    (o_test_ray),
        .o_test_sphere (o_test_sphere),
        .o_test_color  (o_test_color),
        .o_test_pi     (o_test_pi),
        .o_test_st     (o_test_st),
        .i_test_hit    (i_test_hit),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res_hit     (o_res_hit)
    );

    // Primitive memory contents: sphere word bit 32 = hit flag, bits 31:0 = T
    logic [SPH_W-1:0] mem_sph [N];
    logic [COL_W-1:0] mem_col [N];
    logic [ST_W-1:0]  mem_st  [N];

    // Memory: one-cycle read latency, junk on the bus when no read was issued
    always @(posedge clk) begin
        if (o_sph_rd) begin
            i_sph_data  <= mem_sph[o_sph_addr];
            i_sph_color <= mem_col[o_sph_addr];
            i_sph_st    <= mem_st[o_sph_addr];
        end else begin
            i_sph_data  <= {$urandom, $urandom, $urandom, $urandom};
            i_sph_color <= COL_W'($urandom);
            i_sph_st    <= ST_W'($urandom);
        end
    end

    // SphereHit stand-in
    assign i_test_hit = {o_test_sphere[32], o_test_sphere[31:0] + o_test_ray[31:0],
                         o_test_pi, o_test_color, o_test_st};

    int n_tests = 0;
    int n_fail  = 0;

    bit               act = 1'b0;
    int               cyc;
    int               e_lat;
    int               e_rel;
    int               e_nreads;
    logic [IDX_W-1:0] e_first;
    logic [HIT_W-1:0] e_hit;
    logic [HIT_W-1:0] got_res;
    int               got_lat;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic set_sph(input int idx, input bit hit, input logic [31:0] t);
        mem_sph[idx]        = {$urandom, $urandom, $urandom, $urandom};
        mem_sph[idx][32]    = hit;
        mem_sph[idx][31:0]  = t;
        mem_col[idx]        = COL_W'($urandom);
        mem_st[idx]         = ST_W'($urandom);
    endtask

    // Reference model: walk the index range in issue order and pick the result
    task automatic model(input logic [IDX_W-1:0] first, input int count, input bit any,
                         input logic [31:0] roff);
        bit               found = 1'b0;
        logic [31:0]      bt = '0;
        logic [31:0]      t;
        logic [IDX_W-1:0] bidx = '0;
        logic [IDX_W-1:0] idx;
        int               k_hit = -1;
        for (int k = 0; k < count; k++) begin
            idx = IDX_W'(first + k);
            if (mem_sph[idx][32]) begin
                t = mem_sph[idx][31:0] + roff;
                if (!found || $signed(t) < $signed(bt)) begin
                    found = 1'b1;
                    bt    = t;
                    bidx  = idx;
                end
                if (any) begin
                    k_hit = k;
                    break;
                end
            end
        end
        e_hit = found ? {1'b1, bt, PI_W'(bidx), mem_col[bidx], mem_st[bidx]} : '0;
        if (count == 0) begin
            e_lat    = 1;
            e_nreads = 0;
        end else if (k_hit >= 0) begin
            e_lat    = k_hit + 4;
            e_nreads = (k_hit + 2 < count) ? k_hit + 2 : count;
        end else begin
            e_lat    = count + 3;
            e_nreads = count;
        end
    endtask

    // Per-cycle comparison against the model while a request is in progress
    always @(negedge clk) begin
        if (act) begin
            if (cyc == 0) begin
                chk("req_ready_idle", 128'(o_req_ready), 128'(1));
                chk("res_valid_idle", 128'(o_res_valid), 128'(0));
                chk("sph_rd_idle", 128'(o_sph_rd), 128'(0));
            end else begin
                if (cyc <= e_rel) chk("req_ready_busy", 128'(o_req_ready), 128'(0));
                chk("sph_rd", 128'(o_sph_rd), 128'(cyc <= e_nreads));
                if (cyc <= e_nreads)
                    chk("sph_addr", 128'(o_sph_addr), 128'(IDX_W'(e_first + IDX_W'(cyc - 1))));
                chk("res_valid", 128'(o_res_valid), 128'(cyc >= e_lat && cyc <= e_rel));
                if (o_res_valid && got_lat < 0) begin
                    got_lat = cyc;
                    got_res = o_res_hit;
                end
                if (cyc >= e_lat && cyc <= e_rel) chk("res_hit", 128'(o_res_hit), 128'(e_hit));
                if (cyc == e_rel + 1) begin
                    chk("req_ready_back", 128'(o_req_ready), 128'(1));
                    act = 1'b0;
                end
            end
            cyc++;
        end
    end

    task automatic run_req(input logic [IDX_W-1:0] first, input int count, input bit any,
                           input logic [31:0] roff, input int hold);
        logic [RAY_W-1:0] ray;
        model(first, count, any, roff);
        @(posedge clk);
        #1;
        ray        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ray[31:0]  = roff;
        i_ray      = ray;
        i_first    = first;
        i_count    = (IDX_W + 1)'(count);
        i_any_hit  = any;
        i_req_valid = 1'b1;
        i_res_ready = 1'b0;
        e_first    = first;
        e_rel      = e_lat + hold;
        got_lat    = -1;
        got_res    = '0;
        cyc        = 0;
        act        = 1'b1;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_ray       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        i_first     = IDX_W'($urandom);
        i_count     = (IDX_W + 1)'($urandom);
        i_any_hit   = ~any;
        repeat (e_rel - 1) @(posedge clk);
        #1;
        i_res_ready = 1'b1;
        @(posedge clk);
        #1;
        i_res_ready = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 128'(o_req_ready), 128'(1));
        chk({tag, "_sph_rd"}, 128'(o_sph_rd), 128'(0));
        chk({tag, "_sph_addr"}, 128'(o_sph_addr), 128'(0));
        chk({tag, "_res_valid"}, 128'(o_res_valid), 128'(0));
        chk({tag, "_res_hit"}, 128'(o_res_hit), 128'(0));
        chk({tag, "_test_sphere"}, 128'(o_test_sphere), 128'(0));
        chk({tag, "_test_ray"}, 128'(o_test_ray != '0), 128'(0));
        chk({tag, "_test_pi"}, 128'(o_test_pi), 128'(0));
        chk({tag, "_test_color"}, 128'({o_test_color, o_test_st}), 128'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) set_sph(i, 1'b0, $urandom);

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // Empty range
        run_req(6'd5, 0, 1'b0, '0, 0);
        chk("cnt0_bhit", 128'(got_res[74]), 128'(0));
        chk("cnt0_lat", 128'(got_lat), 128'(1));

        // Nearest of four, tie between 5 and 6 keeps 5
        set_sph(4, 1'b1, FX_5);
        set_sph(5, 1'b1, FX_2);
        set_sph(6, 1'b1, FX_2);
        set_sph(7, 1'b1, FX_7);
        run_req(6'd4, 4, 1'b0, '0, 0);
        chk("near4_pi", 128'(got_res[41:26]), 128'(5));
        chk("near4_t", 128'(got_res[73:42]), 128'(FX_2));
        chk("near4_lat", 128'(got_lat), 128'(7));

        // Any-hit: first hit at index 2, later closer hits must not be taken
        for (int i = 0; i < 8; i++) set_sph(i, 1'b0, FX_1);
        set_sph(2, 1'b1, FX_3);
        set_sph(3, 1'b1, FX_0_5);
        set_sph(6, 1'b1, FX_0_25);
        run_req(6'd0, 8, 1'b1, '0, 0);
        chk("any_pi", 128'(got_res[41:26]), 128'(2));
        chk("any_t", 128'(got_res[73:42]), 128'(FX_3));
        chk("any_lat", 128'(got_lat), 128'(6));

        // Address wrap, no hits inside range (hits just outside at 61 and 2)
        set_sph(62, 1'b0, FX_1);
        set_sph(63, 1'b0, FX_1);
        set_sph(61, 1'b1, FX_1);
        run_req(6'd62, 4, 1'b0, '0, 0);
        chk("wrap_bhit", 128'(got_res[74]), 128'(0));

        // Signed compare, tie, ray offset, result held for 10 cycles
        set_sph(20, 1'b1, FX_3);
        set_sph(21, 1'b1, FX_M1_5);
        set_sph(22, 1'b0, FX_MIN);
        set_sph(23, 1'b1, FX_M1_5);
        set_sph(24, 1'b1, FX_10);
        run_req(6'd20, 5, 1'b0, FX_1, 10);
        chk("signed_pi", 128'(got_res[41:26]), 128'(21));
        chk("signed_t", 128'(got_res[73:42]), 128'(FX_M0_5));

        // Full 64-entry scan
        run_req(6'd0, 64, 1'b0, '0, 0);
        chk("full_pi", 128'(got_res[41:26]), 128'(21));
        chk("full_t", 128'(got_res[73:42]), 128'(FX_M1_5));
        chk("full_lat", 128'(got_lat), 128'(67));

        // Any-hit with no hit in range, and any-hit on a single sphere
        run_req(6'd30, 5, 1'b1, '0, 0);
        chk("anynone_bhit", 128'(got_res[74]), 128'(0));
        run_req(6'd6, 1, 1'b1, FX_4, 2);
        chk("anyone_t", 128'(got_res[73:42]), 128'(FX_4 + FX_0_25));

        // Reset during the third read; stale data in 10..15 would win if it leaked
        for (int i = 10; i < 16; i++) set_sph(i, 1'b1, FX_MIN);
        @(posedge clk);
        #1;
        i_first     = 6'd10;
        i_count     = 7'd6;
        i_any_hit   = 1'b0;
        i_req_valid = 1'b1;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_rd", 128'(o_sph_rd), 128'(1));
        chk("rst_mid_addr", 128'(o_sph_addr), 128'(12));
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        reset = 1'b0;
        run_req(6'd20, 5, 1'b0, '0, 0);
        chk("after_rst_pi", 128'(got_res[41:26]), 128'(21));
        chk("after_rst_t", 128'(got_res[73:42]), 128'(FX_M1_5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
